// File: rtl/dmem_stall_responder.sv
// Multi-cycle data-memory responder for the memory stage: holds one word
// request for LATENCY cycles (stall), then completes it with a done pulse.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   enable, wr    request valid / 1=write, sampled together
//   addr          byte address; addr[0] must be 0, word = addr[DEPTH_LOG2:1]
//   data_in       write data
//   createdump    halt request; freezes the responder until rst
//   data_out      read data, valid with done on reads, held otherwise
//   done          one-cycle completion pulse
//   stall         request outstanding (state == BUSY)
//   err           one-cycle misaligned-access pulse
//   halted        sticky halt status
module dmem_stall_responder #(
  parameter int DEPTH_LOG2 = 13,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        createdump,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic        halted
);

  localparam int AW = DEPTH_LOG2;
  localparam int WORDS = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   dout_q, dout_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          halted_q, halted_d;
  logic          mem_we;

  logic [15:0] mem_q [WORDS];

  // Upper address bits are deliberately ignored (accesses wrap).
  logic unused_addr;
  assign unused_addr = ^addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  // Storage is not reset; mem_we is low whenever rst holds state in IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (createdump) begin
          state_d = S_HALT;
        end else if (enable && !addr[0]) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (createdump) begin
          state_d = S_HALT;
        end else if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    halted_d = halted_q | createdump;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // createdump outranks a new request, including its err.
        if (!createdump && enable) begin
          if (addr[0]) begin
            err_d = 1'b1;
          end else begin
            wr_d    = wr;
            idx_d   = addr[AW:1];
            wdata_d = data_in;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_BUSY: begin
        if (!createdump) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            done_d = 1'b1;
            if (wr_q) begin
              mem_we = 1'b1;
            end else begin
              dout_d = mem_q[idx_q];
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign data_out = dout_q;
  assign done     = done_q;
  assign err      = err_q;
  assign halted   = halted_q;
  assign stall    = (state_q == S_BUSY);

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Bench for dmem_stall_responder: vector table plus hand sequences for
// back-to-back, halt, async reset and address wrap (second small instance).
module tb_dmem_stall_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_en, a_wr, a_dump;
  logic [15:0] a_addr, a_din, a_dout;
  logic        a_done, a_stall, a_err, a_halt;

  logic        b_en, b_wr, b_dump;
  logic [15:0] b_addr, b_din, b_dout;
  logic        b_done, b_stall, b_err, b_halt;

  dmem_stall_responder #(.DEPTH_LOG2(13), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .enable(a_en), .wr(a_wr), .addr(a_addr),
    .data_in(a_din), .createdump(a_dump), .data_out(a_dout),
    .done(a_done), .stall(a_stall), .err(a_err), .halted(a_halt)
  );

  dmem_stall_responder #(.DEPTH_LOG2(4), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .enable(b_en), .wr(b_wr), .addr(b_addr),
    .data_in(b_din), .createdump(b_dump), .data_out(b_dout),
    .done(b_done), .stall(b_stall), .err(b_err), .halted(b_halt)
  );

  logic        sel;
  logic [15:0] o_dout;
  logic        o_done, o_stall, o_err;
  assign o_dout  = sel ? b_dout  : a_dout;
  assign o_done  = sel ? b_done  : a_done;
  assign o_stall = sel ? b_stall : a_stall;
  assign o_err   = sel ? b_err   : a_err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [15:0] rd;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] last_rd[2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit s, bit en, bit w, logic [15:0] ad,
                       logic [15:0] d, bit dump);
    if (!s) begin
      a_en = en; a_wr = w; a_addr = ad; a_din = d; a_dump = dump;
    end else begin
      b_en = en; b_wr = w; b_addr = ad; b_din = d; b_dump = dump;
    end
  endtask

  task automatic do_req(bit w, logic [15:0] ad, logic [15:0] d,
                        output bit got_done, output int st_cnt,
                        output int err_cnt);
    int   idle;
    exp_t e;
    got_done = 1'b0;
    st_cnt = 0;
    err_cnt = 0;
    idle = 0;
    @(negedge clk);
    drive(sel, 1'b1, w, ad, d, 1'b0);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (o_stall) st_cnt++;
      if (o_err) err_cnt++;
      if (o_done) begin
        got_done = 1'b1;
        chk("done_err_excl", {31'd0, o_err}, 32'd0);
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk(e.wr ? "dout_hold_on_wr" : "rdata", {16'd0, o_dout},
              {16'd0, e.rd});
        end
        break;
      end
      if (!o_stall) begin
        idle++;
        if (idle >= 3) break;
      end
      @(negedge clk);
    end
  endtask

  task automatic xfer(bit w, logic [15:0] ad, logic [15:0] d,
                      logic [15:0] exp_rd);
    bit gd;
    int sc, ec;
    sbq.push_back('{w, w ? last_rd[sel] : exp_rd});
    do_req(w, ad, d, gd, sc, ec);
    chk("xfer_done", {31'd0, gd}, 32'd1);
    chk("xfer_stall_cycles", sc, sel ? 32'd1 : 32'd2);
    chk("xfer_no_err", ec, 32'd0);
    if (!w) last_rd[sel] = exp_rd;
  endtask

  task automatic wait_done(string nm, output int k);
    k = 0;
    while (!o_done && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'd0, o_done}, 32'd1);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_halted", {31'd0, a_halt}, 32'd0);
    chk("rst_stall", {31'd0, a_stall}, 32'd0);
    #1;
    rst = 1'b0;
    last_rd[0] = 16'h0;
  endtask

  vec_t tbl[9];

  initial begin
    bit gd;
    int sc, ec, k, bad;

    tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    tbl[2] = '{1'b1, 16'h0012, 16'h1111, 1'b0, 16'h0000};
    tbl[3] = '{1'b0, 16'h0013, 16'h0000, 1'b1, 16'h0000};
    tbl[4] = '{1'b0, 16'h0012, 16'h0000, 1'b0, 16'h1111};
    tbl[5] = '{1'b1, 16'h0100, 16'hCAFE, 1'b0, 16'h0000};
    tbl[6] = '{1'b0, 16'h0100, 16'h0000, 1'b0, 16'hCAFE};
    tbl[7] = '{1'b1, 16'h4010, 16'h1357, 1'b0, 16'h0000};
    tbl[8] = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1357};

    sel = 1'b0;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #12;
    chk("rst_a_dout", {16'd0, a_dout}, 32'd0);
    chk("rst_a_flags", {28'd0, a_done, a_stall, a_err, a_halt}, 32'd0);
    chk("rst_b_dout", {16'd0, b_dout}, 32'd0);
    chk("rst_b_flags", {28'd0, b_done, b_stall, b_err, b_halt}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].exp_err) begin
        do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, gd, sc, ec);
        chk("misalign_err_once", ec, 32'd1);
        chk("misalign_no_done", {31'd0, gd}, 32'd0);
        chk("misalign_no_stall", sc, 32'd0);
      end else begin
        xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
      end
    end

    // Back-to-back with ignored requests while busy.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0030, 16'h0A0A, 1'b0);
    @(negedge clk);
    chk("b2b_stall", {31'd0, a_stall}, 32'd1);
    drive(1'b0, 1'b1, 1'b1, 16'h0100, 16'hDEAD, 1'b0);
    wait_done("b2b_done1", k);
    chk("b2b_lat1", k, 32'd2);
    drive(1'b0, 1'b1, 1'b1, 16'h0032, 16'h0B0B, 1'b0);
    @(negedge clk);
    chk("b2b_no_gap", {31'd0, a_stall}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_done("b2b_done2", k);
    xfer(1'b0, 16'h0100, 16'h0, 16'hCAFE);
    xfer(1'b0, 16'h0030, 16'h0, 16'h0A0A);
    xfer(1'b0, 16'h0032, 16'h0, 16'h0B0B);

    // Async reset in the middle of a write.
    xfer(1'b1, 16'h0040, 16'h3333, 16'h0);
    xfer(1'b0, 16'h0040, 16'h0, 16'h3333);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0040, 16'h7777, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("mid_rst_busy", {31'd0, a_stall}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", {16'd0, a_dout}, 32'd0);
    chk("mid_rst_flags", {28'd0, a_done, a_stall, a_err, a_halt}, 32'd0);
    #1;
    rst = 1'b0;
    last_rd[0] = 16'h0;
    xfer(1'b0, 16'h0040, 16'h0, 16'h3333);

    // Halt one cycle after accepting a write.
    xfer(1'b1, 16'h0020, 16'h1234, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h5678, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("halt_set", {31'd0, a_halt}, 32'd1);
    chk("halt_no_stall", {31'd0, a_stall}, 32'd0);
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      if (a_done || a_stall || a_err) bad++;
      drive(1'b0, 1'b1, j[0], 16'h0020 | 16'(j[0]), 16'h9999, 1'b0);
      @(negedge clk);
    end
    if (a_done || a_stall || a_err) bad++;
    chk("halt_ignores", bad, 32'd0);
    chk("halt_sticky", {31'd0, a_halt}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    pulse_rst();
    xfer(1'b0, 16'h0020, 16'h0, 16'h1234);

    // createdump together with a misaligned request: halt, no err.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0013, 16'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("dump_wins_err", {31'd0, a_err}, 32'd0);
    chk("dump_wins_halt", {31'd0, a_halt}, 32'd1);
    pulse_rst();

    // Small instance: wrap-around at 16 words, LATENCY=1.
    sel = 1'b1;
    xfer(1'b1, 16'h0022, 16'hAAAA, 16'h0);
    xfer(1'b0, 16'h0002, 16'h0, 16'hAAAA);
    xfer(1'b1, 16'h0004, 16'h5555, 16'h0);
    xfer(1'b0, 16'h0024, 16'h0, 16'h5555);
    sel = 1'b0;

    chk("sb_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_stall_responder.md
Name: dmem_stall_responder

Overview:
- Data-memory responder for the processor's memory stage.
- Accepts one word request (read or write) from the memory-stage initiator and holds it for a programmable number of cycles, signalling `stall` while busy.
- Completes the access with a one-cycle `done` pulse.
- Flags misaligned word accesses and freezes itself when a halt dump is requested.

Parameters:
- `DEPTH_LOG2`, default 13: log2 of the number of 16-bit words stored (8192 words = 16 KB).
- `LATENCY`, default 2: cycles from acceptance to completion. Legal range is 1..15.

Ports:
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: request valid.
- `wr` in 1: 1 = write, 0 = read. Sampled with `enable`.
- `addr` in 16: byte address. `addr[0]` must be 0.
- `data_in` in 16: write data.
- `createdump` in 1: halt; freezes the responder.
- `data_out` out 16: read data. Valid when `done`=1 and the request was a read.
- `done` out 1: one-cycle completion pulse.
- `stall` out 1: request outstanding; new requests are ignored.
- `err` out 1: one-cycle misalignment error pulse.
- `halted` out 1: sticky halt status.

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - On reset: state=IDLE, counter=0, latched request cleared.
  - Outputs during/after reset: `data_out`=0, `done`=0, `stall`=0, `err`=0, `halted`=0.
  - The storage array is not reset; its contents are undefined until written.
  - Reset mid-request abandons the request: no write commits and no `done` is produced.
- States: IDLE, BUSY, HALT.
- IDLE:
  - Edge with `enable`=1, `addr[0]`=0, `createdump`=0: latch `wr`, `addr[DEPTH_LOG2:1]`, `data_in`. Set counter=LATENCY-1 and go to BUSY.
  - Edge with `enable`=1, `addr[0]`=1, `createdump`=0: no access, stay in IDLE, `err`<=1 for the next cycle only.
  - `enable`=0: remain in IDLE.
- BUSY:
  - `stall`=1 (registered, equal to state==BUSY).
  - `enable`, `addr`, `wr` and `data_in` are ignored; the initiator re-presents after `done`.
  - Each edge: if counter≠0, decrement. If counter==0, perform the access, assert `done`<=1 and return to IDLE.
  - Write: the array word is updated at that edge.
  - Read: `data_out`<=array word at that edge.
- Latency: a request sampled at edge E0 produces `done` high during the cycle after edge E(LATENCY). Example: LATENCY=2 gives `done` two cycles after acceptance.
- Back-to-back requests: the cycle in which `done`=1 is IDLE, so a new request may be sampled at its closing edge. Sustained throughput is 1 request per LATENCY+1 cycles.
- Hazards: read-after-write to the same address returns the new data. There is no internal forwarding requirement beyond ordering.
- `data_out`:
  - Holds its last read value until the next read completes.
  - Writes do not change it.
  - Value while `done`=0 is don't-care for the initiator, but must be stable.
- Addressing: word index = `addr[DEPTH_LOG2:1]`. Upper address bits are ignored, so accesses wrap modulo 2^DEPTH_LOG2 words.
- `createdump` sampled high at any edge: next state is HALT and `halted`<=1.
  - If in BUSY, the outstanding request is dropped: no commit, no `done`.
  - In HALT: `stall`=0, `done`=0, `err`=0, all requests ignored, array frozen. HALT is left only via `rst`.
- Simultaneous `createdump` and a new request in IDLE: `createdump` wins, the request is not accepted, and no `err` is raised even if misaligned.
- `err` and `done` are never high in the same cycle.

Test Plan:
- Write then read, LATENCY=2: write `addr`=0x0010, `data_in`=0xBEEF. Expect `stall`=1 for 2 cycles and `done` on cycle 3. Read 0x0010: `data_out`=0xBEEF with `done`, and `err`=0 throughout.
- Misaligned access: read `addr`=0x0013. Expect `err`=1 for exactly one cycle, `stall`=0, `done`=0. Array unchanged: reading 0x0012 returns its prior value.
- Back-to-back and ignored input: re-present a write at the `done` cycle; it is accepted with no gap. `enable` pulses during BUSY with `addr`=0x0100 do not alter the array; reading 0x0100 still shows the old value.
- Halt mid-request: write 0x0020=0x1234 complete, then write 0x0020=0x5678 with `createdump` one cycle after acceptance. Expect `halted`=1, no `done`, and later requests ignored. After `rst`, reading 0x0020 returns 0x1234.
- Async reset mid-BUSY: assert `rst` between edges. `stall`, `done`, `err` and `data_out` drop to 0 immediately. No commit occurs, and the next request behaves normally.
- Wrap-around with DEPTH_LOG2=4: write `addr`=0x0022 with 0xAAAA. A read of `addr`=0x0002 returns 0xAAAA.
